simd_alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the 32-bit multi-operation ALU: LANES independent lanes of LANE_W bits each, executed lane-parallel for the AES SIMD datapath.
- Single-cycle ops (add/sub/mul/logic) complete with a latency of 1 cycle.
- GF(2^LANE_W) multiply (AES MixColumns) is computed iteratively over LANE_W cycles, all lanes in parallel.
- Sits between the vector register file read stage and writeback; valid/ready on both sides.

---
 rtl/simd_alu_pipe_if.sv | 29 ++
 rtl/simd_alu_pipe.sv | 139 +++++++++++++
 tb/tb_simd_alu_pipe.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/simd_alu_pipe_if.sv
// Operand/result bundle for the lane-parallel SIMD ALU stage.
// Valid/ready semantics: a transfer occurs on a rising edge where valid && ready; the producer holds its payload stable while valid && !ready.
interface simd_alu_pipe_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
);
    localparam int VW = LANES * LANE_W;

    logic             in_valid;
    logic             in_ready;
    logic [VW-1:0]    a;
    logic [VW-1:0]    b;
    logic [2:0]       select;
    logic             out_valid;
    logic             out_ready;
    logic [VW-1:0]    result;
    logic [LANES-1:0] carry;
    logic             busy;

    modport master (
        output in_valid, a, b, select, out_ready,
        input  in_ready, out_valid, result, carry, busy
    );

    modport slave (
        input  in_valid, a, b, select, out_ready,
        output in_ready, out_valid, result, carry, busy
    );
endinterface

// File: rtl/simd_alu_pipe.sv
// Lane-parallel SIMD ALU: single-cycle add/sub/mul/logic ops plus an iterative
// GF(2^LANE_W) multiply that runs one Horner step per cycle across all lanes.
module simd_alu_pipe #(
    parameter int                LANES   = 4,
    parameter int                LANE_W  = 8,
    parameter logic [LANE_W-1:0] GF_POLY = 8'h1B
) (
    input  logic            clk,
    input  logic            rst,
    simd_alu_pipe_if.slave  bus,
    output logic            dbg_state_o
);
    localparam int VW = LANES * LANE_W;
    localparam int CW = (LANE_W > 1) ? $clog2(LANE_W) : 1;

    typedef enum logic {IDLE = 1'b0, GF_BUSY = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [VW-1:0]    a_q, a_d, b_q, b_d, p_q, p_d;
    logic [VW-1:0]    result_q, result_d;
    logic [LANES-1:0] carry_q, carry_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready;
    logic             accept;
    logic [VW-1:0]    alu_res;
    logic [LANES-1:0] alu_carry;
    logic [VW-1:0]    gf_step;
    logic [LANE_W:0]  op_r;

    // Returns {carry, value} for one lane; the GF code is handled by the FSM.
    function automatic logic [LANE_W:0] lane_op(input logic [2:0] sel,
                                                input logic [LANE_W-1:0] x,
                                                input logic [LANE_W-1:0] y);
        logic [LANE_W:0] r;
        r = '0;
        case (sel)
            3'b000:  r = {1'b0, x} + {1'b0, y};
            3'b001:  r = {1'b0, x} - {1'b0, y};
            3'b010:  r[LANE_W-1:0] = x * y;
            3'b011:  r[LANE_W-1:0] = x ^ y;
            3'b100:  r[LANE_W-1:0] = x & y;
            3'b110:  r[LANE_W-1:0] = x | y;
            3'b111:  r[LANE_W-1:0] = x;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [LANE_W-1:0] xtime(input logic [LANE_W-1:0] x);
        return {x[LANE_W-2:0], 1'b0} ^ (x[LANE_W-1] ? GF_POLY : '0);
    endfunction

    assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        alu_res   = '0;
        alu_carry = '0;
        gf_step   = '0;
        op_r      = '0;
        for (int i = 0; i < LANES; i++) begin
            op_r = lane_op(bus.select, bus.a[i*LANE_W +: LANE_W], bus.b[i*LANE_W +: LANE_W]);
            alu_res[i*LANE_W +: LANE_W] = op_r[LANE_W-1:0];
            alu_carry[i]                = op_r[LANE_W];
            gf_step[i*LANE_W +: LANE_W] = xtime(p_q[i*LANE_W +: LANE_W]) ^
                (b_q[i*LANE_W + int'(cnt_q)] ? a_q[i*LANE_W +: LANE_W] : '0);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        result_d    = result_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.select == 3'b101) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        p_d     = '0;
                        cnt_d   = CW'(LANE_W - 1);
                        state_d = GF_BUSY;
                    end else begin
                        result_d    = alu_res;
                        carry_d     = alu_carry;
                        out_valid_d = 1'b1;
                    end
                end
            end
            GF_BUSY: begin
                p_d   = gf_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    result_d    = gf_step;
                    carry_d     = '0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            result_q    <= '0;
            carry_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.busy      = (state_q == GF_BUSY);
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed bench for simd_alu_pipe: vector table for single-cycle ops, hand
// sequences for GF latency, backpressure and reset abort.
module tb_simd_alu_pipe;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int VW     = LANES * LANE_W;

  typedef struct {
    string            name;
    logic [2:0]       sel;
    logic [VW-1:0]    a;
    logic [VW-1:0]    b;
    logic [VW-1:0]    r;
    logic [LANES-1:0] c;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  int   checks = 0;
  int   errors = 0;
  logic [VW+LANES-1:0] exp_q[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  simd_alu_pipe_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

  simd_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .GF_POLY(8'h1B)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op and holds it until accepted; returns #1 after the accept edge.
  task automatic send(input logic [2:0] sel, input logic [VW-1:0] av, input logic [VW-1:0] bv);
    int n;
    bus.in_valid = 1'b1;
    bus.select   = sel;
    bus.a        = av;
    bus.b        = bv;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 after 50 cycles, expected 1");
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string name);
    logic [VW+LANES-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: expected queue empty, expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({name, "_result"}, 64'(bus.result), 64'(e[VW-1:0]));
      chk({name, "_carry"}, 64'(bus.carry), 64'(e[VW+LANES-1:VW]));
    end
  endtask

  task automatic gf_run(input string name, input logic [VW-1:0] av, input logic [VW-1:0] bv,
                        input logic [VW-1:0] r);
    send(3'b101, av, bv);
    exp_q.push_back({4'b0000, r});
    for (int k = 0; k < 8; k++) begin
      chk({name, "_busy_phase"}, 64'({bus.busy, bus.in_ready, bus.out_valid, dbg_state}), 64'b1001);
      tick();
    end
    check_result(name);
    chk({name, "_busy_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{"add_basic",  3'b000, 32'h01010101, 32'h01010101, 32'h02020202, 4'b0000};
    vecs[1]  = '{"add_lane3c", 3'b000, 32'hFF000001, 32'h01000001, 32'h00000002, 4'b1000};
    vecs[2]  = '{"sub_pos",    3'b001, 32'h00000005, 32'h00000003, 32'h00000002, 4'b0000};
    vecs[3]  = '{"sub_borrow", 3'b001, 32'h00000003, 32'h00000005, 32'h000000FE, 4'b0001};
    vecs[4]  = '{"mul_small",  3'b010, 32'h00000002, 32'h00000003, 32'h00000006, 4'b0000};
    vecs[5]  = '{"mul_wrap",   3'b010, 32'h10101010, 32'h10101010, 32'h00000000, 4'b0000};
    vecs[6]  = '{"xor",        3'b011, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 4'b0000};
    vecs[7]  = '{"and",        3'b100, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 4'b0000};
    vecs[8]  = '{"or",         3'b110, 32'h12345678, 32'h80808080, 32'h92B4D6F8, 4'b0000};
    vecs[9]  = '{"pass_a",     3'b111, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF, 4'b0000};
    vecs[10] = '{"add_mixed",  3'b000, 32'h80FF7F01, 32'h80017F01, 32'h0000FE02, 4'b1100};
    vecs[11] = '{"sub_mixed",  3'b001, 32'h00800001, 32'h01010002, 32'hFF7F00FF, 4'b1001};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.select    = '0;
    tick();
    tick();
    chk("reset_outputs", 64'({bus.out_valid, bus.busy, bus.in_ready, bus.carry, bus.result}), 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("post_reset_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].sel, vecs[i].a, vecs[i].b);
      exp_q.push_back({vecs[i].c, vecs[i].r});
      check_result(vecs[i].name);
    end

    gf_run("gf_by_one_lane0", 32'hA2AF2F63, 32'h00000001, 32'h00000063);
    gf_run("gf_by_ones",      32'hA2AF2F63, 32'h01010101, 32'hA2AF2F63);
    gf_run("gf_fips197",      32'h57575757, 32'h83130201, 32'hC1FEAE57);

    // Backpressure: hold a result, then drain and accept on the same edge.
    tick();
    chk("drained_before_bp", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
    send(3'b000, 32'h01020304, 32'h01010101);
    exp_q.push_back({4'b0000, 32'h02030405});
    check_result("bp_add");
    bus.in_valid = 1'b1;
    bus.select   = 3'b011;
    bus.a        = 32'hFFFF0000;
    bus.b        = 32'h0F0F0F0F;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_flags", 64'({bus.out_valid, bus.in_ready}), 64'b10);
      chk("bp_hold_data", 64'({bus.carry, bus.result}), 64'({4'b0000, 32'h02030405}));
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    exp_q.push_back({4'b0000, 32'hF0F00F0F});
    check_result("drain_accept");
    tick();
    chk("drain_clear", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a GF iteration aborts it with no output.
    send(3'b101, 32'h57575757, 32'h83130201);
    tick();
    tick();
    tick();
    chk("gf_mid_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("abort_outputs", 64'({bus.out_valid, bus.busy, bus.in_ready, dbg_state, bus.carry, bus.result}), 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready", 64'(bus.in_ready), 64'd1);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (bus.out_valid) seen = 1'b1;
        tick();
      end
      chk("abort_no_output", 64'(seen), 64'd0);
    end
    send(3'b000, 32'h01010101, 32'h02020202);
    exp_q.push_back({4'b0000, 32'h03030303});
    check_result("add_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units, expected completion");
    $fatal(1);
  end
endmodule
